// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag record shared by the alu_seq slice.
package alu_seq_pkg;
  localparam logic [3:0] OP_LAND = 4'd0;
  localparam logic [3:0] OP_BAND = 4'd1;
  localparam logic [3:0] OP_LOR  = 4'd2;
  localparam logic [3:0] OP_BOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LXOR = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_MOV  = 4'd11;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between operand fetch, alu_seq and writeback.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  modport master (
    output in_valid, op, a, b, set_flags, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );
  modport slave (
    input  in_valid, op, a, b, set_flags, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: WIDTH-cycle unsigned shift-add multiplier; done flags the final iteration,
// during which product already carries the completed low WIDTH bits.
module alu_seq_mul #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] acc, mcand, mplier, step;
  logic [CW-1:0]    cnt;
  assign step    = acc + (mplier[0] ? mcand : '0);
  assign done    = cnt == CW'(1);
  assign product = step;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute unit with N/Z/C/V flags and ADC/SBC carry chaining.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for opcode 10.
module alu_seq
  import alu_seq_pkg::*;
#(parameter int WIDTH = 32) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  state_t           state;
  flags_t           flags, nf, mf;
  logic [0:WIDTH-1] res, r, bp, sum, prod;
  logic [WIDTH:0]   ext;
  logic             valid, accept, sub, arith, cin, is_mul, mul_done, mul_sf;
  assign sub    = bus.op == OP_SUB || bus.op == OP_SBC;
  assign arith  = sub || bus.op == OP_ADD || bus.op == OP_ADC;
  // SUB forces carry-in 1 (two's complement); ADC/SBC chain the stored C flag
  assign cin    = bus.op == OP_SUB || ((bus.op == OP_ADC || bus.op == OP_SBC) && flags.c);
  assign bp     = sub ? ~bus.b : bus.b;
  assign ext    = {1'b0, bus.a} + {1'b0, bp} + (WIDTH+1)'(cin);
  assign sum    = ext[WIDTH-1:0];
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    r = bus.a;
    case (bus.op)
      OP_LAND: r = WIDTH'((|bus.a) && (|bus.b));
      OP_BAND: r = bus.a & bus.b;
      OP_LOR:  r = WIDTH'((|bus.a) || (|bus.b));
      OP_BOR:  r = bus.a | bus.b;
      OP_XOR:  r = bus.a ^ bus.b;
      OP_LXOR: r = WIDTH'((|bus.a) ^ (|bus.b));
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: r = sum;
      OP_MOV:  r = bus.b;
      default: r = bus.a;
    endcase
  end
  assign nf = '{n: r[0], z: r == '0,
                c: arith ? ext[WIDTH] : flags.c,
                v: arith ? (bus.a[0] == bp[0] && r[0] != bus.a[0]) : flags.v};
  assign mf = '{n: prod[0], z: prod == '0, c: flags.c, v: flags.v};
`ifdef ALU_SEQ_MUL_EN
  assign is_mul = bus.op == OP_MUL;
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign prod     = '0;
`endif
  assign bus.in_ready  = state != S_MUL && (!valid || bus.out_ready);
  assign bus.out_valid = valid;
  assign bus.result    = res;
  assign bus.flag_n    = flags.n;
  assign bus.flag_z    = flags.z;
  assign bus.flag_c    = flags.c;
  assign bus.flag_v    = flags.v;
  // accept takes priority over drain so HOLD sustains one op per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      res    <= '0;
      valid  <= 1'b0;
      flags  <= '0;
      mul_sf <= 1'b0;
    end else if (accept && !is_mul) begin
      res   <= r;
      valid <= 1'b1;
      state <= S_HOLD;
      if (bus.set_flags) flags <= nf;
    end else if (accept) begin
      valid  <= 1'b0;
      mul_sf <= bus.set_flags;
      state  <= S_MUL;
    end else if (mul_done && state == S_MUL) begin
      res   <= prod;
      valid <= 1'b1;
      state <= S_HOLD;
      if (mul_sf) flags <= mf;
    end else if (valid && bus.out_ready) begin
      valid <= 1'b0;
      state <= S_IDLE;
    end
  end
endmodule
